serdes_tx_gearbox: RTL and testbench
====================================

SERDES_TX_GEARBOX -- requirements
Module: serdes_tx_gearbox

Interface
REQ-001 SHALL have parameter IDLE_WORD, default 8'h00: byte driven to the serializer when no data or training is active.
REQ-002 SHALL have parameter TRAIN_WORD, default 8'h6A: byte driven repeatedly while link training is active.
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 4, legal range 2..15: number of CLK cycles SER_RST stays high after RST deasserts.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 CLK  input  1  serializer divided clock; all logic is clocked on the rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 IN_DATA  input  32  word to transmit; byte 0 is IN_DATA[7:0].
REQ-008 IN_VALID  input  1  IN_DATA is valid.
REQ-009 IN_READY  output  1  block accepts IN_DATA this cycle.
REQ-010 TRAIN  input  1  level request for the training pattern.
REQ-011 SER_D  output  8  parallel byte to the serializer; SER_D[0] feeds D1 and is the first bit on the line.
REQ-012 SER_OCE  output  1  serializer output clock enable.
REQ-013 SER_RST  output  1  serializer reset.
REQ-014 BUSY  output  1  high while a word is being sent (SEND state).
REQ-015 TX_COUNT  output  16  count of accepted words.

Function
REQ-016 SHALL drive every output from a register; there is no combinational path from any input to any output.
REQ-017 SHALL implement states WAKE, IDLE, SEND and TRAIN; the reset state is WAKE.
REQ-018 WAKE SHALL hold SER_RST=1, SER_OCE=0, SER_D=IDLE_WORD and IN_READY=0 for RST_HOLD_CYCLES cycles after RST falls, then go to IDLE.
REQ-019 In IDLE, TRAIN and SEND, SER_RST SHALL be 0 and SER_OCE SHALL be 1.
REQ-020 IDLE SHALL drive SER_D=IDLE_WORD, and SHALL drive IN_READY=1 when TRAIN=0.
REQ-021 A transfer SHALL occur only on a cycle where IN_VALID=1 and IN_READY=1.
REQ-022 On a transfer, the block SHALL capture IN_DATA, enter SEND and increment TX_COUNT by 1, wrapping from 16'hFFFF to 0.
REQ-023 Latency: a word transferred in cycle N SHALL appear on SER_D as byte 0 in N+1, byte 1 in N+2, byte 2 in N+3 and byte 3 in N+4.
REQ-024 In SEND, IN_READY SHALL be 1 only in the cycle that registers byte 3 for output, and only when TRAIN=0.
REQ-025 Back-to-back words SHALL be sent with no idle byte between them, giving a sustained rate of 1 word per 4 cycles.
REQ-026 If no transfer occurs at the end of a word, the block SHALL go to TRAIN if TRAIN=1, otherwise to IDLE.
REQ-027 TRAIN SHALL NOT interrupt a word in progress; it is sampled only in IDLE or at a word boundary.
REQ-028 At a boundary, TRAIN=1 SHALL take priority over IN_VALID=1: IN_READY stays 0 and no transfer occurs.
REQ-029 TRAIN state SHALL drive SER_D=TRAIN_WORD and IN_READY=0 each cycle, and SHALL return to IDLE in the cycle after TRAIN is sampled 0.
REQ-030 IN_DATA SHALL be ignored whenever IN_READY=0; once the word is captured, IN_VALID and IN_DATA changes SHALL have no effect on the word in flight.
REQ-031 BUSY SHALL be 1 exactly in the cycles where SER_D carries a data byte.

Reset
REQ-032 While RST=1, outputs SHALL be: SER_D=IDLE_WORD, SER_OCE=0, SER_RST=1, IN_READY=0, BUSY=0, TX_COUNT=0, state=WAKE.
REQ-033 RST asserted mid-word SHALL abort the word immediately (asynchronously), with no partial bytes emitted after RST falls.
REQ-034 The WAKE sequence SHALL restart in full after every reset.

Verification
REQ-035 Reset release, RST_HOLD_CYCLES=4 -> SER_RST=1 and SER_OCE=0 for exactly 4 cycles, then IDLE with SER_D=8'h00 and IN_READY=1.
REQ-036 Single word 32'hDDCCBBAA accepted in cycle N -> SER_D=AA,BB,CC,DD in N+1..N+4, BUSY=1 in those cycles, then 8'h00, TX_COUNT=1.
REQ-037 Two words with IN_VALID held high -> 8 consecutive data bytes with no idle byte between them, and IN_READY high exactly once per 4 cycles.
REQ-038 TRAIN raised during byte 1 of a word with another word pending -> the current word completes, then 8'h6A repeats with IN_READY=0; TRAIN falls -> IDLE next cycle, then the pending word is accepted.
REQ-039 TX_COUNT preset by sending 65535 words, then one more word -> TX_COUNT wraps to 16'h0000.
REQ-040 RST pulsed during byte 2 -> outputs take reset values immediately, and the full WAKE sequence repeats after RST falls.

Source files
------------

// File: rtl/serdes_tx_gearbox.sv
// serdes_tx_gearbox: 32-bit word to 8-bit serializer gearbox.
// Accepts a word through a valid/ready handshake and emits it as four bytes,
// byte 0 first. Holds the serializer in reset after system reset (WAKE),
// idles with IDLE_WORD, and sends TRAIN_WORD while link training is requested.
//
// Ports
//   clk       in   serializer divided clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_data   in   [31:0] word to transmit, byte 0 = in_data[7:0]
//   in_valid  in   in_data is valid
//   in_ready  out  word accepted this cycle when in_valid is also high
//   train     in   level request for the training pattern
//   ser_d     out  [7:0] parallel byte to the serializer
//   ser_oce   out  serializer output clock enable
//   ser_rst   out  serializer reset
//   busy      out  high while ser_d carries a data byte
//   tx_count  out  [15:0] number of accepted words, wraps
// Every output is a flop; no input reaches an output combinationally.
module serdes_tx_gearbox #(
   parameter logic [7:0]  IDLE_WORD       = 8'h00,
   parameter logic [7:0]  TRAIN_WORD      = 8'h6A,
   parameter int unsigned RST_HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        train,
   output logic [7:0]  ser_d,
   output logic        ser_oce,
   output logic        ser_rst,
   output logic        busy,
   output logic [15:0] tx_count
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned REST_W = DATA_W - BYTE_W;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WAKE_W = 4;
   localparam int unsigned IDX_W  = 2;

   // Final WAKE count; the transition to IDLE happens on the edge that sees it.
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(RST_HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_B2    = IDX_W'(2);
   localparam logic [IDX_W-1:0]  IDX_B3    = IDX_W'(3);

   typedef enum logic [1:0] {
      WAKE  = 2'd0,
      IDLE  = 2'd1,
      SEND  = 2'd2,
      TRAIN = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [WAKE_W-1:0]   wake_cnt, wake_cnt_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;         // index of the byte currently on ser_d
   logic [REST_W-1:0]   rest, rest_nxt;       // bytes of the word not yet on ser_d
   logic [BYTE_W-1:0]   ser_d_nxt;
   logic                ser_oce_nxt;
   logic                ser_rst_nxt;
   logic                in_ready_nxt;
   logic                busy_nxt;
   logic [CNT_W-1:0]    tx_count_nxt;
   logic                load;
   logic                xfer;

   // Handshake uses the registered ready, so the transfer decision is local.
   assign xfer = in_valid & in_ready;

   // Accepted-word counter, wraps naturally at 16 bits.
   assign tx_count_nxt = xfer ? tx_count + CNT_W'(1) : tx_count;

   // Next state and next registered output values.
   always_comb begin
      state_nxt    = state;
      wake_cnt_nxt = wake_cnt;
      idx_nxt      = idx;
      rest_nxt     = rest;
      ser_d_nxt    = IDLE_WORD;
      ser_oce_nxt  = 1'b1;
      ser_rst_nxt  = 1'b0;
      in_ready_nxt = 1'b0;
      busy_nxt     = 1'b0;
      load         = 1'b0;

      unique case (state)
         WAKE: begin
            if (wake_cnt == WAKE_LAST) begin
               state_nxt    = IDLE;
               in_ready_nxt = ~train;
            end else begin
               wake_cnt_nxt = wake_cnt + WAKE_W'(1);
               ser_oce_nxt  = 1'b0;
               ser_rst_nxt  = 1'b1;
            end
         end

         IDLE: begin
            if (xfer) begin
               load = 1'b1;
            end else if (train) begin
               state_nxt = TRAIN;
               ser_d_nxt = TRAIN_WORD;
            end else begin
               in_ready_nxt = 1'b1;
            end
         end

         SEND: begin
            if (idx != IDX_B3) begin
               ser_d_nxt    = rest[BYTE_W-1:0];
               rest_nxt     = {BYTE_W'(0), rest[REST_W-1:BYTE_W]};
               idx_nxt      = idx + IDX_W'(1);
               busy_nxt     = 1'b1;
               // Ready is offered alongside byte 3 so the next word follows gaplessly.
               in_ready_nxt = (idx == IDX_B2) && !train;
            end else if (xfer) begin
               load = 1'b1;
            end else if (train) begin
               state_nxt = TRAIN;
               ser_d_nxt = TRAIN_WORD;
            end else begin
               state_nxt    = IDLE;
               in_ready_nxt = 1'b1;
            end
         end

         TRAIN: begin
            if (train) begin
               ser_d_nxt = TRAIN_WORD;
            end else begin
               state_nxt    = IDLE;
               in_ready_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = WAKE;
         end
      endcase

      // Capture a new word: byte 0 goes straight to the output register.
      if (load) begin
         state_nxt    = SEND;
         idx_nxt      = '0;
         ser_d_nxt    = in_data[BYTE_W-1:0];
         rest_nxt     = in_data[DATA_W-1:BYTE_W];
         busy_nxt     = 1'b1;
         in_ready_nxt = 1'b0;
      end
   end

   // State and output registers; reset aborts any word in flight at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= WAKE;
         wake_cnt <= '0;
         idx      <= '0;
         rest     <= '0;
         ser_d    <= IDLE_WORD;
         ser_oce  <= 1'b0;
         ser_rst  <= 1'b1;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         tx_count <= '0;
      end else begin
         state    <= state_nxt;
         wake_cnt <= wake_cnt_nxt;
         idx      <= idx_nxt;
         rest     <= rest_nxt;
         ser_d    <= ser_d_nxt;
         ser_oce  <= ser_oce_nxt;
         ser_rst  <= ser_rst_nxt;
         in_ready <= in_ready_nxt;
         busy     <= busy_nxt;
         tx_count <= tx_count_nxt;
      end
   end

endmodule

// File: tb/tb_serdes_tx_gearbox.sv
// Bench for serdes_tx_gearbox: per-cycle vector table with a byte scoreboard,
// plus hand-written reset, counter-wrap and mid-word reset sequences.
module tb_serdes_tx_gearbox;

   localparam int unsigned HOLD = 4;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        train;
   logic [7:0]  ser_d;
   logic        ser_oce;
   logic        ser_rst;
   logic        busy;
   logic [15:0] tx_count;

   serdes_tx_gearbox #(
      .IDLE_WORD      (8'h00),
      .TRAIN_WORD     (8'h6A),
      .RST_HOLD_CYCLES(HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .train   (train),
      .ser_d   (ser_d),
      .ser_oce (ser_oce),
      .ser_rst (ser_rst),
      .busy    (busy),
      .tx_count(tx_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row per cycle: inputs driven in that cycle, outputs expected in it.
   typedef struct {
      logic        vld;
      logic [31:0] data;
      logic        trn;
      logic        exp_ready;
      logic        exp_busy;
      logic [7:0]  exp_d;      // compared only when exp_busy is 0
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  exp_q[$];      // scoreboard of data bytes still to appear
   logic [15:0] exp_cnt;
   int          vectors;
   int          miscompares;

   function automatic vec_t v(input logic vld, input logic [31:0] data, input logic trn,
                              input logic rdy, input logic bsy, input logic [7:0] d);
      vec_t r;
      r.vld = vld; r.data = data; r.trn = trn;
      r.exp_ready = rdy; r.exp_busy = bsy; r.exp_d = d;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare this cycle's outputs, then drive this cycle's inputs.
   task automatic apply(input vec_t r);
      logic [7:0] b;
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(r.exp_ready));
      check("busy", 32'(busy), 32'(r.exp_busy));
      if (r.exp_busy) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: data byte %0h seen, expected none queued", ser_d);
         end else begin
            b = exp_q.pop_front();
            check("ser_d_data", 32'(ser_d), 32'(b));
         end
      end else begin
         check("ser_d_fill", 32'(ser_d), 32'(r.exp_d));
      end
      check("ser_oce", 32'(ser_oce), 32'd1);
      check("ser_rst", 32'(ser_rst), 32'd0);
      check("tx_count", 32'(tx_count), 32'(exp_cnt));
      in_valid = r.vld;
      in_data  = r.data;
      train    = r.trn;
      if (r.vld && r.exp_ready) begin
         for (int i = 0; i < 4; i++) exp_q.push_back(r.data[8*i +: 8]);
         exp_cnt = exp_cnt + 16'd1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ser_d"}, 32'(ser_d), 32'h00);
      check({tag, "_ser_oce"}, 32'(ser_oce), 32'd0);
      check({tag, "_ser_rst"}, 32'(ser_rst), 32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_tx_count"}, 32'(tx_count), 32'h0);
   endtask

   // Release reset on a falling edge and check the full WAKE sequence.
   task automatic release_and_wake();
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < int'(HOLD); k++) begin
         if (k > 0) @(negedge clk);
         check("wake_ser_rst", 32'(ser_rst), 32'd1);
         check("wake_ser_oce", 32'(ser_oce), 32'd0);
         check("wake_in_ready", 32'(in_ready), 32'd0);
         check("wake_ser_d", 32'(ser_d), 32'h00);
      end
      @(negedge clk);
      check("idle_ser_rst", 32'(ser_rst), 32'd0);
      check("idle_ser_oce", 32'(ser_oce), 32'd1);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_ser_d", 32'(ser_d), 32'h00);
   endtask

   task automatic send_word(input logic [31:0] w);
      apply(v(1'b1, w, 1'b0, 1'b1, 1'b0, 8'h00));
      apply(v(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00));
      apply(v(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00));
      apply(v(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00));
      apply(v(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 8'h00));
      apply(v(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_cnt     = 16'h0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = 32'h0;
      train       = 1'b0;

      // Single word
      vecs.push_back(v(1, 32'hDDCCBBAA, 0, 1, 0, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 1, 1, 8'h00));
      // Back-to-back words, valid held high, extra data ignored while not ready
      vecs.push_back(v(1, 32'h44332211, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 32'h88776655, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'h88776655, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'h88776655, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'h88776655, 0, 1, 1, 8'h00));
      vecs.push_back(v(1, 32'hDEADBEEF, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hDEADBEEF, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hDEADBEEF, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 1, 1, 8'h00));
      // Train raised during byte 1 with a word pending
      vecs.push_back(v(1, 32'hA3A2A1A0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 32'hB3B2B1B0, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hB3B2B1B0, 1, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hB3B2B1B0, 1, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hB3B2B1B0, 1, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hB3B2B1B0, 1, 0, 0, 8'h6A));
      vecs.push_back(v(1, 32'hB3B2B1B0, 0, 0, 0, 8'h6A));
      vecs.push_back(v(1, 32'hB3B2B1B0, 0, 1, 0, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 1, 1, 8'h00));
      // Train from IDLE; valid ignored while training
      vecs.push_back(v(0, 32'h0, 1, 1, 0, 8'h00));
      vecs.push_back(v(1, 32'hC3C2C1C0, 1, 0, 0, 8'h6A));
      vecs.push_back(v(1, 32'hC3C2C1C0, 0, 0, 0, 8'h6A));
      vecs.push_back(v(1, 32'hC3C2C1C0, 0, 1, 0, 8'h00));
      // Train pulse during byte 2 wins the boundary over a pending word
      vecs.push_back(v(1, 32'hD3D2D1D0, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hD3D2D1D0, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hD3D2D1D0, 1, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hD3D2D1D0, 0, 0, 1, 8'h00));
      vecs.push_back(v(1, 32'hD3D2D1D0, 0, 1, 0, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 0, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 1, 1, 8'h00));
      vecs.push_back(v(0, 32'h0, 0, 1, 0, 8'h00));

      // Outputs held at reset values while rst is high
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      release_and_wake();

      foreach (vecs[i]) apply(vecs[i]);
      check("count_after_table", 32'(tx_count), 32'd7);

      // Counter wrap: preload 16'hFFFF through the next-count net (sending
      // 65535 real words would take far too long), then send one more word.
      force dut.tx_count_nxt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.tx_count_nxt;
      exp_cnt = 16'hFFFF;
      send_word(32'h04030201);
      check("count_wrap", 32'(tx_count), 32'h0);

      // Reset asserted while byte 2 is on the line
      apply(v(1, 32'h0F0E0D0C, 0, 1, 0, 8'h00));
      apply(v(0, 32'h0, 0, 0, 1, 8'h00));
      apply(v(0, 32'h0, 0, 0, 1, 8'h00));
      apply(v(0, 32'h0, 0, 0, 1, 8'h00));
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      exp_q.delete();
      exp_cnt = 16'h0;
      @(negedge clk);
      check_reset_outputs("held_rst");
      release_and_wake();
      send_word(32'h11223344);
      check("count_after_rst", 32'(tx_count), 32'd1);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
